peripheral_dsa_vector_dot_engine: RTL
=====================================

# peripheral_dsa_vector_dot_engine

Parametrised streaming vector engine for the DSA peripheral. It accepts two operand vectors element by element through independent A/B enable strobes and has two modes. In dot-product mode it multiply-accumulates the pairs into one scalar. In element-wise mode it emits one product per pair. It sits behind the peripheral bus adapter and generalises the fixed 512-bit datapath to arbitrary width, vector length and mode.

## Interface
- DATA_SIZE, 512, element/result width in bits; unsigned
- CONTROL_SIZE, 64, width of the vector length and index counter
- CLK  in  1  clock, rising edge
- RST  in  1  reset; asynchronous, active-high
- START  in  1  begin an operation; sampled only in IDLE
- READY  out  1  one-cycle pulse: operation complete
- MODE_IN  in  1  latched at START: 0 = dot product, 1 = element-wise product
- SIZE_IN  in  CONTROL_SIZE  vector length, latched at START
- DATA_ENABLE  out  1  high while the engine accepts elements
- DATA_A_IN_ENABLE  in  1  DATA_A_IN valid this cycle
- DATA_A_IN  in  DATA_SIZE  operand A element
- DATA_B_IN_ENABLE  in  1  DATA_B_IN valid this cycle
- DATA_B_IN  in  DATA_SIZE  operand B element
- DATA_OUT  out  DATA_SIZE  result: dot scalar or element product
- DATA_OUT_ENABLE  out  1  one-cycle pulse: DATA_OUT valid

## Operation
- FSM states are IDLE, INPUT and ENDER.
- IDLE, START=1 at an edge:
  - Latch SIZE_IN and MODE_IN.
  - Clear the accumulator, index and A/B hold flags.
  - SIZE_IN≠0: go to INPUT and set DATA_ENABLE=1.
  - SIZE_IN=0: go to ENDER.
- START is ignored in INPUT and ENDER.
- INPUT, operand capture:
  - An A element is present if DATA_A_IN_ENABLE=1 or the A hold flag is set; B is handled the same way.
  - A lone A with no B: store it and set the A hold flag.
  - Another A strobe while the A hold flag is set and no B is present is ignored; the first value is kept. B is symmetric.
  - Strobes outside INPUT are ignored.
- Pairing edge: both A and B are present. Live inputs take priority only when no hold value exists. At this edge:
  - p = (A*B) mod 2^DATA_SIZE.
  - Dot mode: acc <= (acc + p) mod 2^DATA_SIZE.
  - Element-wise mode: DATA_OUT <= p and DATA_OUT_ENABLE <= 1.
  - Clear both hold flags and increment the index.
- If index+1 = SIZE at the pairing edge: DATA_ENABLE <= 0 and go to ENDER.
- ENDER, always one cycle, then go to IDLE:
  - READY <= 1.
  - Dot mode: DATA_OUT <= acc and DATA_OUT_ENABLE <= 1.
  - Element-wise mode: DATA_OUT holds the last product and DATA_OUT_ENABLE <= 0.
- SIZE=0 cases:
  - Dot mode: DATA_OUT=0 with DATA_OUT_ENABLE pulse and READY.
  - Element-wise mode: READY only.
- Arithmetic is unsigned. Products and the accumulator wrap silently, with no overflow flag.

## Timing
- Reset values: READY=0, DATA_ENABLE=0, DATA_OUT=0, DATA_OUT_ENABLE=0; state IDLE, accumulator/index/flags 0.
- RST mid-operation aborts immediately. Partial results are discarded and no READY is produced.
- All outputs are registered.
- DATA_ENABLE rises in the cycle after the START edge.
- Pairing rate: at most one pair per cycle; A and B may arrive in the same cycle or any cycles apart.
- Element-wise latency: a pair sampled at edge k drives DATA_OUT_ENABLE high for the cycle after k. The signal stays high across consecutive pairing edges.
- Completion: last pair at edge k → READY (and dot DATA_OUT_ENABLE) high for exactly the cycle after edge k+1.
- SIZE=0: READY is high in the cycle after edge s+1, where s is the START edge.
- Back-to-back: START sampled while READY is high is accepted, because the state is already IDLE.

## Test plan
- Dot, DATA_SIZE=16, SIZE=3, A={1,2,3} and B={4,5,6}, each pair in the same cycle → DATA_OUT=32 with DATA_OUT_ENABLE and READY both in the cycle after edge k+1, exactly one cycle each.
- Staggered arrival: A0=7 at cycle 2, B0=3 at cycle 5; duplicate A=9 at cycle 3; SIZE=1 dot → DATA_OUT=21 (the 9 is ignored).
- Element-wise, SIZE=4, A={2,3,4,5} and B={10,10,10,10}, back-to-back → DATA_OUT_ENABLE high for 4 consecutive cycles carrying 20, 30, 40, 50; READY one cycle later; DATA_ENABLE low after the 4th pair.
- Wrap, DATA_SIZE=8, dot, A={255,255} and B={255,2} → p = {1, 254}, acc = 255.
- SIZE=0 in both modes → dot mode: READY with DATA_OUT=0; element-wise mode: READY with no DATA_OUT_ENABLE. START during INPUT is ignored and the index is unchanged.
- RST asserted asynchronously mid-vector (after 2 of 5 pairs) → all outputs 0 immediately. A subsequent fresh START with SIZE=1 (A=3, B=3) yields 9, with no residue from the aborted run.

Source files
------------

// File: rtl/peripheral_dsa_vector_dot_engine.sv
// Streaming vector engine: pairs A/B elements arriving on independent strobes and
// either accumulates their products (dot mode) or streams each product out (element-wise mode).
module peripheral_dsa_vector_dot_engine #(
  parameter int DATA_SIZE    = 512,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic                    MODE_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_IN,
  output logic                    DATA_ENABLE,
  input  logic                    DATA_A_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    DATA_A_IN,
  input  logic                    DATA_B_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    DATA_B_IN,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    DATA_OUT_ENABLE
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INPUT,
    ST_ENDER
  } state_t;

  state_t                  r_state;
  logic                    r_mode;
  logic [CONTROL_SIZE-1:0] r_size;
  logic [CONTROL_SIZE-1:0] r_idx;
  logic [DATA_SIZE-1:0]    r_acc;
  logic [DATA_SIZE-1:0]    r_a_val;
  logic [DATA_SIZE-1:0]    r_b_val;
  logic                    r_a_hold;
  logic                    r_b_hold;

  logic                    w_a_pres;
  logic                    w_b_pres;
  logic [DATA_SIZE-1:0]    w_a_sel;
  logic [DATA_SIZE-1:0]    w_b_sel;
  logic                    w_pair;
  logic [DATA_SIZE-1:0]    w_prod;
  logic [CONTROL_SIZE-1:0] w_idx_nxt;
  logic                    w_last;

  // Products and sums keep only the low DATA_SIZE bits; overflow wraps silently.
  function automatic logic [DATA_SIZE-1:0] f_wrap_mul(input logic [DATA_SIZE-1:0] a,
                                                      input logic [DATA_SIZE-1:0] b);
    return a * b;
  endfunction

  function automatic logic [DATA_SIZE-1:0] f_wrap_add(input logic [DATA_SIZE-1:0] a,
                                                      input logic [DATA_SIZE-1:0] b);
    return a + b;
  endfunction

  // A held operand wins over a live strobe so the first arrival is never overwritten.
  assign w_a_pres  = r_a_hold | DATA_A_IN_ENABLE;
  assign w_b_pres  = r_b_hold | DATA_B_IN_ENABLE;
  assign w_a_sel   = r_a_hold ? r_a_val : DATA_A_IN;
  assign w_b_sel   = r_b_hold ? r_b_val : DATA_B_IN;
  assign w_pair    = w_a_pres & w_b_pres;
  assign w_prod    = f_wrap_mul(w_a_sel, w_b_sel);
  assign w_idx_nxt = r_idx + CONTROL_SIZE'(1);
  assign w_last    = (w_idx_nxt == r_size);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state         <= ST_IDLE;
      r_mode          <= 1'b0;
      r_size          <= '0;
      r_idx           <= '0;
      r_acc           <= '0;
      r_a_val         <= '0;
      r_b_val         <= '0;
      r_a_hold        <= 1'b0;
      r_b_hold        <= 1'b0;
      READY           <= 1'b0;
      DATA_ENABLE     <= 1'b0;
      DATA_OUT        <= '0;
      DATA_OUT_ENABLE <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          READY           <= 1'b0;
          DATA_OUT_ENABLE <= 1'b0;
          if (START) begin
            r_size   <= SIZE_IN;
            r_mode   <= MODE_IN;
            r_acc    <= '0;
            r_idx    <= '0;
            r_a_hold <= 1'b0;
            r_b_hold <= 1'b0;
            if (SIZE_IN != '0) begin
              DATA_ENABLE <= 1'b1;
              r_state     <= ST_INPUT;
            end else begin
              r_state <= ST_ENDER;
            end
          end
        end

        ST_INPUT: begin
          READY           <= 1'b0;
          DATA_OUT_ENABLE <= 1'b0;
          if (w_pair) begin
            if (r_mode) begin
              DATA_OUT        <= w_prod;
              DATA_OUT_ENABLE <= 1'b1;
            end else begin
              r_acc <= f_wrap_add(r_acc, w_prod);
            end
            r_a_hold <= 1'b0;
            r_b_hold <= 1'b0;
            r_idx    <= w_idx_nxt;
            if (w_last) begin
              DATA_ENABLE <= 1'b0;
              r_state     <= ST_ENDER;
            end
          end else begin
            // Only one side present: park it until its partner shows up.
            if (DATA_A_IN_ENABLE && !r_a_hold) begin
              r_a_val  <= DATA_A_IN;
              r_a_hold <= 1'b1;
            end
            if (DATA_B_IN_ENABLE && !r_b_hold) begin
              r_b_val  <= DATA_B_IN;
              r_b_hold <= 1'b1;
            end
          end
        end

        ST_ENDER: begin
          READY   <= 1'b1;
          r_state <= ST_IDLE;
          if (!r_mode) begin
            DATA_OUT        <= r_acc;
            DATA_OUT_ENABLE <= 1'b1;
          end else begin
            DATA_OUT_ENABLE <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
